reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_if.sv | 25 ++
 rtl/reg_file.sv | 76 +++++++
 tb/tb_reg_file.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Register file access bundle: two read ports, one write port, a0 view.
// Master drives indices and write data; slave returns read data.
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  we;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [DATA_WIDTH-1:0] a0;

  modport master (
    output rs1_addr, rs2_addr, rd_addr, rd_data, we,
    input  rs1_data, rs2_data, a0
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_addr, rd_data, we,
    output rs1_data, rs2_data, a0
  );
endinterface

// File: rtl/reg_file.sv
// RISC-V integer register file: 2 comb read ports, 1 write port, x0 tied 0.
// Optional write-through bypass on read ports: define REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);
  localparam int NREG   = 2 ** ADDR_WIDTH;
  localparam int A0_IDX = 10;

  logic [DATA_WIDTH-1:0] regs [0:NREG-1];
  logic                  wr_en;

  assign wr_en = bus.we && (bus.rd_addr != '0);

  // Storage update: reset clears all, otherwise write non-zero index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.rd_addr] <= bus.rd_data;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic hit1;
  logic hit2;

  assign hit1 = wr_en && (bus.rs1_addr == bus.rd_addr);
  assign hit2 = wr_en && (bus.rs2_addr == bus.rd_addr);

  // Port 1 read: reset wins, then write-through, then stored value.
  always_comb begin
    bus.rs1_data = '0;
    if (rst || bus.rs1_addr == '0)
      bus.rs1_data = '0;
    else if (hit1)
      bus.rs1_data = bus.rd_data;
    else
      bus.rs1_data = regs[bus.rs1_addr];
  end

  // Port 2 read: reset wins, then write-through, then stored value.
  always_comb begin
    bus.rs2_data = '0;
    if (rst || bus.rs2_addr == '0)
      bus.rs2_data = '0;
    else if (hit2)
      bus.rs2_data = bus.rd_data;
    else
      bus.rs2_data = regs[bus.rs2_addr];
  end
`else
  // Port 1 read: stored value, x0 forced to zero.
  always_comb begin
    bus.rs1_data = '0;
    if (bus.rs1_addr != '0)
      bus.rs1_data = regs[bus.rs1_addr];
  end

  // Port 2 read: stored value, x0 forced to zero.
  always_comb begin
    bus.rs2_data = '0;
    if (bus.rs2_addr != '0)
      bus.rs2_data = regs[bus.rs2_addr];
  end
`endif

  // a0 is the raw stored x10, never bypassed.
  assign bus.a0 = regs[A0_IDX];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file with a queue scoreboard.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string         nm;
    int            cyc;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] a0;
  } exp_t;

  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(string nm, string f,
                     logic [DW-1:0] act, logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %h want %h", nm, f, act, req);
    end
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale cyc %0d want %0d", e.nm, cyc, e.cyc);
      end else begin
        cmp(e.nm, "rs1", bus.rs1_data, e.r1);
        cmp(e.nm, "rs2", bus.rs2_data, e.r2);
        cmp(e.nm, "a0", bus.a0, e.a0);
      end
    end
  end

  task automatic drive(logic r, logic w, logic [AW-1:0] wa,
                       logic [DW-1:0] wd, logic [AW-1:0] a1,
                       logic [AW-1:0] a2);
    @(posedge clk);
    #1;
    rst          = r;
    bus.we       = w;
    bus.rd_addr  = wa;
    bus.rd_data  = wd;
    bus.rs1_addr = a1;
    bus.rs2_addr = a2;
  endtask

  task automatic expect_now(string nm, logic [DW-1:0] r1,
                            logic [DW-1:0] r2, logic [DW-1:0] a0);
    exp_t e;
    e.nm  = nm;
    e.cyc = cyc;
    e.r1  = r1;
    e.r2  = r2;
    e.a0  = a0;
    q.push_back(e);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.we       = 1'b0;
    bus.rd_addr  = '0;
    bus.rd_data  = '0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;

    // reset then read
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 5, 31);
    expect_now("rst_read", 0, 0, 0);

    // write x3, read same cycle and next
    drive(0, 1, 3, 32'hDEADBEEF, 3, 4);
    expect_now("wr3_same", BYP ? 32'hDEADBEEF : 32'h0, 0, 0);
    drive(0, 0, 0, 0, 3, 4);
    expect_now("wr3_next", 32'hDEADBEEF, 0, 0);

    // x0 guard
    drive(0, 1, 0, 32'hFFFFFFFF, 0, 3);
    expect_now("x0_same", 0, 32'hDEADBEEF, 0);
    drive(0, 0, 0, 0, 0, 0);
    expect_now("x0_next", 0, 0, 0);

    // same-cycle hazard on x7, both ports same index
    drive(0, 1, 7, 32'h11, 1, 2);
    drive(0, 1, 7, 32'h22, 7, 7);
    expect_now("haz_same", BYP ? 32'h22 : 32'h11,
               BYP ? 32'h22 : 32'h11, 0);
    drive(0, 0, 0, 0, 7, 3);
    expect_now("haz_next", 32'h22, 32'hDEADBEEF, 0);

    // x10 write, a0 not bypassed
    drive(0, 1, 10, 32'h5, 10, 0);
    expect_now("x10_same", BYP ? 32'h5 : 32'h0, 0, 0);
    drive(0, 0, 0, 0, 10, 10);
    expect_now("x10_next", 32'h5, 32'h5, 32'h5);

    // reset priority over write
    drive(1, 1, 10, 32'h99, 10, 7);
    expect_now("rstpri_same", BYP ? 32'h0 : 32'h5,
               BYP ? 32'h0 : 32'h22, 32'h5);
    drive(0, 0, 0, 0, 10, 7);
    expect_now("rstpri_next", 0, 0, 0);

    // write gating and a0
    drive(0, 0, 10, 32'h1234, 10, 3);
    expect_now("we0_same", 0, 0, 0);
    drive(0, 0, 10, 32'h1234, 10, 3);
    expect_now("we0_next", 0, 0, 0);
    drive(0, 1, 10, 32'h1234, 10, 3);
    expect_now("we1_same", BYP ? 32'h1234 : 32'h0, 0, 0);
    drive(0, 0, 0, 0, 10, 3);
    expect_now("we1_next", 32'h1234, 0, 32'h1234);

    // full-width indices, no aliasing
    drive(0, 1, 31, 32'hA5A5A5A5, 0, 0);
    drive(0, 1, 15, 32'h0F0F0F0F, 0, 0);
    drive(0, 1, 18, 32'hCAFEF00D, 31, 15);
    expect_now("hi_idx", 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h1234);
    drive(0, 0, 0, 0, 2, 18);
    expect_now("alias", 0, 32'hCAFEF00D, 32'h1234);
    drive(0, 0, 0, 0, 15, 31);
    expect_now("swap", 32'h0F0F0F0F, 32'hA5A5A5A5, 32'h1234);

    // drain scoreboard with a cycle bound
    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain left %0d want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
